jtdd_sdram_resp: RTL and testbench

- Memory-side responder for the game's ROM request interface: answers sdram_req/sdram_addr with sdram_ack, data_dst, data_rdy and 32-bit data_read.
- Also serves prog_we download writes.
- Backed by a generic 16-bit word memory port with variable latency.
- Used as the SDRAM-controller replacement in simulation and on BRAM/SRAM-backed targets.
- Includes a periodic refresh blackout so the requester sees realistic stalls.

---
 rtl/jtdd_sdram_resp.sv | 160 ++++++++++++++++
 tb/tb_jtdd_sdram_resp.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtdd_sdram_resp.sv
// jtdd_sdram_resp: answers the game's 32-bit ROM read requests and the
// download write stream, using a generic 16-bit memory port that can take
// a variable number of cycles per access. A periodic refresh blackout
// produces realistic request stalls.
module jtdd_sdram_resp #(
  parameter int unsigned AW         = 22,
  parameter int unsigned REF_PERIOD = 384,
  parameter int unsigned REF_LEN    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic          sdram_req,
  input  logic [AW-1:0] sdram_addr,
  output logic          sdram_ack,
  output logic          data_dst,
  output logic          data_rdy,
  output logic [31:0]   data_read,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic [1:0]    prog_mask,
  output logic          mem_rd,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic [1:0]    mem_wmask,
  input  logic [15:0]   mem_din,
  input  logic          mem_valid
);

  localparam int unsigned RCW        = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int unsigned LCW        = (REF_LEN > 1) ? $clog2(REF_LEN) : 1;
  localparam int unsigned REF_LAST_I = (REF_PERIOD > 0) ? REF_PERIOD - 1 : 0;
  localparam int unsigned LEN_LAST_I = (REF_LEN > 0) ? REF_LEN - 1 : 0;
  localparam logic [RCW-1:0] REF_LAST = REF_LAST_I[RCW-1:0];
  localparam logic [LCW-1:0] LEN_LAST = LEN_LAST_I[LCW-1:0];

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_RD0,
    ST_RD1,
    ST_DONE,
    ST_WACK,
    ST_WR,
    ST_REF
  } state_t;

  state_t         state;
  logic [AW-1:0]  rd_addr;
  logic [RCW-1:0] ref_cnt;
  logic [LCW-1:0] len_cnt;
  logic           ref_pend;
  logic           ref_hit;

  // Refresh period counter reaches its last value: a blackout becomes due.
  assign ref_hit = (REF_PERIOD != 0) && (ref_cnt == REF_LAST);

  // Free-running refresh period counter, wraps every REF_PERIOD cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt <= '0;
    end else if (ref_hit) begin
      ref_cnt <= '0;
    end else if (REF_PERIOD != 0) begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Transaction sequencer: arbitration in IDLE, read/write/refresh sequences,
  // all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      sdram_ack <= 1'b0;
      data_dst  <= 1'b0;
      data_rdy  <= 1'b0;
      data_read <= '0;
      mem_rd    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      rd_addr   <= '0;
      len_cnt   <= '0;
      ref_pend  <= 1'b0;
    end else begin
      sdram_ack <= 1'b0;
      data_dst  <= 1'b0;
      data_rdy  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ref_pend) begin
            state    <= ST_REF;
            ref_pend <= 1'b0;
            len_cnt  <= '0;
          end else if (downloading && prog_we) begin
            state     <= ST_WACK;
            sdram_ack <= 1'b1;
            mem_addr  <= prog_addr;
            mem_wdata <= {prog_data, prog_data};
            mem_wmask <= prog_mask;
          end else if (!downloading && sdram_req) begin
            state     <= ST_ACK;
            sdram_ack <= 1'b1;
            rd_addr   <= sdram_addr;
            mem_addr  <= sdram_addr;
          end
        end
        ST_ACK: begin
          mem_rd <= 1'b1;
          state  <= ST_RD0;
        end
        ST_RD0: begin
          if (mem_valid) begin
            data_read[15:0] <= mem_din;
            data_dst        <= 1'b1;
            mem_addr        <= rd_addr + 1'b1;
            state           <= ST_RD1;
          end
        end
        ST_RD1: begin
          if (mem_valid) begin
            data_read[31:16] <= mem_din;
            data_rdy         <= 1'b1;
            mem_rd           <= 1'b0;
            state            <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_WACK: begin
          mem_we <= 1'b1;
          state  <= ST_WR;
        end
        ST_WR: begin
          if (mem_valid) begin
            mem_we <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_REF: begin
          if (len_cnt == LEN_LAST) begin
            state <= ST_IDLE;
          end else begin
            len_cnt <= len_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      // A wrap seen while busy stays pending until the sequencer is back in IDLE.
      if (ref_hit) begin
        ref_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtdd_sdram_resp.sv
// Self-checking bench for jtdd_sdram_resp: table vectors, random traffic
// against a word-level memory model, refresh timing and reset-abort sequences.
`timescale 1ns/1ps
module tb_jtdd_sdram_resp;
  localparam int unsigned AW = 22;
  localparam int NREF = 80;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          downloading = 1'b0;
  logic          sdram_req = 1'b0;
  logic [AW-1:0] sdram_addr = '0;
  logic          sdram_ack;
  logic          data_dst;
  logic          data_rdy;
  logic [31:0]   data_read;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [7:0]    prog_data = '0;
  logic [1:0]    prog_mask = '0;
  logic          mem_rd;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [1:0]    mem_wmask;
  logic [15:0]   mem_din = '0;
  logic          mem_valid = 1'b0;

  always #5 clk = ~clk;

  jtdd_sdram_resp #(.AW(AW), .REF_PERIOD(16), .REF_LEN(4)) dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_din(mem_din), .mem_valid(mem_valid)
  );

  int    passed = 0;
  int    total  = 0;
  string ctx    = "init";

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s [%s]: got %h expected %h", name, ctx, act, exp);
  endfunction

  // Backing store (written by the DUT) and reference image (written by the model).
  logic [15:0] bmem [int unsigned];
  logic [15:0] rmem [int unsigned];

  function automatic logic [15:0] seed_word(logic [AW-1:0] a);
    return a[15:0] ^ {a[21:16], 10'h2A5};
  endfunction
  function automatic logic [15:0] bget(logic [AW-1:0] a);
    return bmem.exists(int'(a)) ? bmem[int'(a)] : seed_word(a);
  endfunction
  function automatic logic [15:0] rget(logic [AW-1:0] a);
    return rmem.exists(int'(a)) ? rmem[int'(a)] : seed_word(a);
  endfunction

  // Variable-latency memory: valid on the lat-th cycle of a held strobe.
  int            lat0_g = 1;
  int            lat1_g = 1;
  logic [AW-1:0] rd_base = '0;
  int            mcnt = 0;
  always @(negedge clk) begin
    int          lat;
    logic [15:0] w;
    if (mem_rd || mem_we) begin
      lat = (mem_we || mem_addr == rd_base) ? lat0_g : lat1_g;
      if (mcnt + 1 >= lat) begin
        mem_valid = 1'b1;
        mcnt = 0;
        if (mem_we) begin
          w = bget(mem_addr);
          if (!mem_wmask[0]) w[7:0]  = mem_wdata[7:0];
          if (!mem_wmask[1]) w[15:8] = mem_wdata[15:8];
          bmem[int'(mem_addr)] = w;
          mem_din = 16'hDEAD;
        end else begin
          mem_din = bget(mem_addr);
        end
      end else begin
        mem_valid = 1'b0;
        mem_din = 16'hDEAD;
        mcnt++;
      end
    end else begin
      mem_valid = 1'b0;
      mcnt = 0;
    end
  end

  logic [31:0] last_read = '0;
  logic [31:0] rd_capture = '0;

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (sdram_ack === 1'b1) got = 1'b1;
    end
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int l0, input int l1);
    logic [AW-1:0] a1;
    logic [31:0]   exp;
    bit            got;
    a1  = a + 22'd1;
    exp = {rget(a1), rget(a)};
    ctx = $sformatf("rd %h lat %0d/%0d", a, l0, l1);
    rd_capture = 'x;
    lat0_g = l0; lat1_g = l1; rd_base = a;
    downloading = 1'b0; prog_we = 1'b0; sdram_req = 1'b1; sdram_addr = a;
    wait_ack(got);
    chk("ack_seen", 32'(got), 32'd1);
    sdram_req = 1'b0;
    if (!got) return;
    for (int k = 1; k <= l0 + l1 + 3; k++) begin
      @(negedge clk);
      chk("rd_single_ack", 32'(sdram_ack), 32'd0);
      chk("mem_rd", 32'(mem_rd), 32'(k <= l0 + l1));
      if (k <= l0) chk("mem_addr_lo", 32'(mem_addr), 32'(a));
      else if (k <= l0 + l1) chk("mem_addr_hi", 32'(mem_addr), 32'(a1));
      chk("data_dst", 32'(data_dst), 32'(k == l0 + 1));
      chk("data_rdy", 32'(data_rdy), 32'(k == l0 + l1 + 1));
      if (k == l0 + 1) begin
        chk("lo_word", 32'(data_read[15:0]), 32'(exp[15:0]));
        chk("hi_hold", 32'(data_read[31:16]), 32'(last_read[31:16]));
      end
      if (k == l0 + l1 + 1) begin
        rd_capture = data_read;
        chk("data_read", data_read, exp);
      end
    end
    last_read = exp;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [7:0] d,
                          input logic [1:0] m, input int l, input bit conc);
    logic [15:0] w;
    bit          got;
    ctx = $sformatf("wr %h d %h m %b lat %0d req %0d", a, d, m, l, conc);
    lat0_g = l; rd_base = a;
    downloading = 1'b1; sdram_req = conc; sdram_addr = a ^ 22'h155;
    prog_we = 1'b1; prog_addr = a; prog_data = d; prog_mask = m;
    wait_ack(got);
    chk("ack_seen", 32'(got), 32'd1);
    prog_we = 1'b0;
    if (!got) begin
      sdram_req = 1'b0;
      return;
    end
    w = rget(a);
    if (!m[0]) w[7:0]  = d;
    if (!m[1]) w[15:8] = d;
    rmem[int'(a)] = w;
    for (int k = 1; k <= l + 4; k++) begin
      @(negedge clk);
      chk("wr_no_ack", 32'(sdram_ack), 32'd0);
      chk("mem_we", 32'(mem_we), 32'(k <= l));
      chk("wr_no_rd", 32'(mem_rd), 32'd0);
      chk("wr_no_dst", 32'(data_dst), 32'd0);
      chk("wr_no_rdy", 32'(data_rdy), 32'd0);
      if (k <= l) begin
        chk("mem_addr_w", 32'(mem_addr), 32'(a));
        chk("mem_wdata", 32'(mem_wdata), 32'({d, d}));
        chk("mem_wmask", 32'(mem_wmask), 32'(m));
      end
    end
    sdram_req = 1'b0;
  endtask

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic [1:0]    mask;
    int            l0;
    int            l1;
    bit            conc;
    logic [31:0]   exp;
  } vec_t;

  vec_t vt [11];

  initial begin
    bit            got;
    bit            rdy_seen;
    bit            exp_ack [0:NREF+8];
    bit            exp_rd  [0:NREF+8];
    bit            exp_rdy [0:NREF+8];
    int            ack_bad, rd_bad, rdy_bad, p, wl, used;
    logic [AW-1:0] pool [8];
    logic [AW-1:0] a;

    vt[0]  = '{1'b0, 22'h000010, 8'h00, 2'b00, 1, 1, 1'b0, 32'hABCD1234};
    vt[1]  = '{1'b0, 22'h000010, 8'h00, 2'b00, 5, 5, 1'b0, 32'hABCD1234};
    vt[2]  = '{1'b0, 22'h3FFFFF, 8'h00, 2'b00, 1, 2, 1'b0, 32'h22221111};
    vt[3]  = '{1'b1, 22'h0C0000, 8'h5A, 2'b10, 1, 0, 1'b1, 32'h0};
    vt[4]  = '{1'b0, 22'h0C0000, 8'h00, 2'b00, 2, 1, 1'b0, 32'h0F0FBE5A};
    vt[5]  = '{1'b1, 22'h0C0001, 8'hC3, 2'b01, 3, 0, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 22'h0C0000, 8'h00, 2'b00, 1, 3, 1'b0, 32'hC30FBE5A};
    vt[7]  = '{1'b1, 22'h0C0000, 8'h77, 2'b11, 2, 0, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 22'h0C0000, 8'h00, 2'b00, 3, 1, 1'b0, 32'hC30FBE5A};
    vt[9]  = '{1'b1, 22'h3FFFFF, 8'h99, 2'b00, 1, 0, 1'b1, 32'h0};
    vt[10] = '{1'b0, 22'h3FFFFF, 8'h00, 2'b00, 1, 1, 1'b0, 32'h22229999};

    // Reset state
    ctx = "reset";
    #1;
    chk("rst_strobes", 32'({sdram_ack, data_dst, data_rdy, mem_rd, mem_we}), 32'd0);
    chk("rst_data_read", data_read, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);

    // Refresh: continuous requests from reset release, 1-cycle memory.
    // Reference: one IDLE decision every 5 cycles; a wrap every 16 cycles
    // becomes visible the cycle after it and is served before the next read.
    ctx = "refresh";
    lat0_g = 1; lat1_g = 1; rd_base = '0;
    sdram_req = 1'b1; sdram_addr = '0;
    for (int c = 0; c <= NREF + 8; c++) begin
      exp_ack[c] = 1'b0; exp_rd[c] = 1'b0; exp_rdy[c] = 1'b0;
    end
    p = 1; used = 0;
    while (p <= NREF) begin
      wl = ((p - 1) / 16) * 16;
      if (wl >= 16 && wl > used) begin
        used = wl;
      end else begin
        exp_ack[p] = 1'b1;
        exp_rd[p+1] = 1'b1;
        exp_rd[p+2] = 1'b1;
        exp_rdy[p+3] = 1'b1;
      end
      p += 5;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    ack_bad = 0; rd_bad = 0; rdy_bad = 0;
    for (int c = 1; c <= NREF; c++) begin
      @(negedge clk);
      if (sdram_ack !== exp_ack[c]) ack_bad++;
      if (mem_rd !== exp_rd[c]) rd_bad++;
      if (data_rdy !== exp_rdy[c]) rdy_bad++;
    end
    chk("ref_ack_cycles_bad", 32'(ack_bad), 32'd0);
    chk("ref_memrd_cycles_bad", 32'(rd_bad), 32'd0);
    chk("ref_rdy_cycles_bad", 32'(rdy_bad), 32'd0);
    sdram_req = 1'b0;
    repeat (8) @(negedge clk);
    last_read = {rget(22'd1), rget(22'd0)};

    // Directed table
    bmem[32'h10] = 16'h1234;     rmem[32'h10] = 16'h1234;
    bmem[32'h11] = 16'hABCD;     rmem[32'h11] = 16'hABCD;
    bmem[32'h3FFFFF] = 16'h1111; rmem[32'h3FFFFF] = 16'h1111;
    bmem[32'h0] = 16'h2222;      rmem[32'h0] = 16'h2222;
    bmem[32'hC0000] = 16'hBEEF;  rmem[32'hC0000] = 16'hBEEF;
    bmem[32'hC0001] = 16'h0F0F;  rmem[32'hC0001] = 16'h0F0F;
    for (int i = 0; i < 11; i++) begin
      if (vt[i].wr) begin
        do_write(vt[i].addr, vt[i].data, vt[i].mask, vt[i].l0, vt[i].conc);
      end else begin
        do_read(vt[i].addr, vt[i].l0, vt[i].l1);
        chk("tbl_read", rd_capture, vt[i].exp);
      end
    end

    // Read request during download is never accepted
    ctx = "req_in_download";
    downloading = 1'b1; sdram_req = 1'b1; sdram_addr = 22'h000010;
    wait_ack(got);
    chk("dl_req_no_ack", 32'(got), 32'd0);
    sdram_req = 1'b0;

    // Random traffic against the reference image
    pool = '{22'h3FFFFE, 22'h000000, 22'h0C0000, 22'h012345,
             22'h2AAAAA, 22'h1FFFFF, 22'h000100, 22'h3FFF00};
    for (int i = 0; i < 60; i++) begin
      a = pool[$urandom_range(0, 7)] + 22'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0)
        do_write(a, 8'($urandom), 2'($urandom), int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
      else
        do_read(a, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
    end

    // Reset between data_dst and data_rdy aborts the read
    ctx = "reset_mid_read";
    lat0_g = 1; lat1_g = 6; rd_base = 22'h20;
    downloading = 1'b0; sdram_req = 1'b1; sdram_addr = 22'h20;
    wait_ack(got);
    chk("ack_seen", 32'(got), 32'd1);
    sdram_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_dst", 32'(data_dst), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_strobes", 32'({sdram_ack, data_dst, data_rdy, mem_rd, mem_we}), 32'd0);
    chk("abort_data_read", data_read, 32'd0);
    chk("abort_mem_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_read = '0;
    rdy_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (data_rdy || mem_rd) rdy_seen = 1'b1;
    end
    chk("no_rdy_after_abort", 32'(rdy_seen), 32'd0);
    do_read(22'h20, 1, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passed, total);
    $fatal(1, "time limit");
  end

endmodule
